wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 88 ++++++++
 tb/tb_wb_port_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the GPR write port between the WB stage and a 2-deep divider result FIFO
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        div_valid,
    input  logic [4:0]  div_waddr,
    input  logic [31:0] div_wdata,
    output logic        div_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        buf_empty
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [1:0]    val_q, val_d;
    logic [4:0]    addr_q [2];
    logic [4:0]    addr_d [2];
    logic [31:0]   data_q [2];
    logic [31:0]   data_d [2];
    logic          rd_q, rd_d, wr_q, wr_d;
    logic [1:0]    occ_q, occ_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          live, head_good, grant_fifo, pipe_grant, pop, enq;
    logic [1:0]    kill;

    // arbitration: pipeline wins unless idle or the buffered head has waited STARVE_LIMIT cycles
    always_comb begin
        live       = pipe_we && pipe_waddr != 5'd0;
        head_good  = occ_q != 2'd0 && val_q[rd_q] && addr_q[rd_q] != 5'd0;
        grant_fifo = head_good && (!live || starve_q == LIMIT);
        pipe_grant = live && !grant_fifo;
        pop        = grant_fifo || (occ_q != 2'd0 && !head_good);
        enq        = div_valid && div_ready;
        kill       = {2{pipe_grant}} & {addr_q[1] == pipe_waddr, addr_q[0] == pipe_waddr};
    end

    assign div_ready  = occ_q != 2'd2;
    assign buf_empty  = occ_q == 2'd0;
    assign pipe_stall = grant_fifo && live;
    assign rf_we      = grant_fifo || pipe_grant;
    assign rf_waddr   = grant_fifo ? addr_q[rd_q] : pipe_grant ? pipe_waddr : 5'd0;
    assign rf_wdata   = grant_fifo ? data_q[rd_q] : pipe_grant ? pipe_wdata : 32'd0;

    // next state: kill on pipeline WAW, pop head, append new divider result, track starvation
    always_comb begin
        val_d  = val_q & ~kill;
        addr_d = addr_q;
        data_d = data_q;
        rd_d   = pop ? ~rd_q : rd_q;
        wr_d   = enq ? ~wr_q : wr_q;
        occ_d  = occ_q + {1'b0, enq} - {1'b0, pop};
        if (pop) val_d[rd_q] = 1'b0;
        if (enq) begin
            val_d[wr_q]  = !(pipe_grant && div_waddr == pipe_waddr);
            addr_d[wr_q] = div_waddr;
            data_d[wr_q] = div_wdata;
        end
        starve_d = (grant_fifo || occ_q == 2'd0) ? '0 :
                   (head_good && starve_q != LIMIT) ? starve_q + SW'(1) : starve_q;
    end

    // state registers with synchronous reset of pointers, occupancy, valids and starvation count
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            occ_q    <= '0;
            starve_q <= '0;
        end else begin
            val_q    <= val_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            occ_q    <= occ_d;
            starve_q <= starve_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors with hand-computed expectations for wb_port_arbiter
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_waddr = '0;
    logic [31:0] pipe_wdata = '0;
    logic        pipe_stall;
    logic        div_valid = 1'b0;
    logic [4:0]  div_waddr = '0;
    logic [31:0] div_wdata = '0;
    logic        div_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        buf_empty;
    int          checks = 0;
    int          errors = 0;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
        .div_valid(div_valid), .div_waddr(div_waddr), .div_wdata(div_wdata), .div_ready(div_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .buf_empty(buf_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic dv, input logic [4:0] da, input logic [31:0] dd);
        @(negedge clk);
        pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
        div_valid = dv; div_waddr = da; div_wdata = dd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic check_write(input string tag, input logic we, input logic [4:0] a,
                               input logic [31:0] d, input logic st);
        check({tag, ".we"}, {63'd0, rf_we}, {63'd0, we});
        check({tag, ".addr"}, {59'd0, rf_waddr}, {59'd0, a});
        check({tag, ".data"}, {32'd0, rf_wdata}, {32'd0, d});
        check({tag, ".stall"}, {63'd0, pipe_stall}, {63'd0, st});
    endtask

    task automatic check_quiet(input string tag);
        check_write(tag, 1'b0, 5'd0, 32'd0, 1'b0);
        check({tag, ".ready"}, {63'd0, div_ready}, 64'd1);
        check({tag, ".empty"}, {63'd0, buf_empty}, 64'd1);
    endtask

    // div r9 buffered under continuous r3 writes: 4 pipe grants, then r9 with stall, then held r3
    task automatic starve_run(input string tag);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
        check_write({tag, ".acc"}, 1'b1, 5'd3, 32'h33, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
            check_write($sformatf("%s.deny%0d", tag, k), 1'b1, 5'd3, 32'h33, 1'b0);
        end
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        check_write({tag, ".grant"}, 1'b1, 5'd9, 32'h99, 1'b1);
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        check_write({tag, ".held"}, 1'b1, 5'd3, 32'h33, 1'b0);
        check({tag, ".empty"}, {63'd0, buf_empty}, 64'd1);
        idle();
    endtask

    initial begin
        drive(1'b1, 5'd7, 32'hDEAD, 1'b1, 5'd8, 32'hBEEF);
        drive(1'b1, 5'd7, 32'hDEAD, 1'b1, 5'd8, 32'hBEEF);
        @(negedge clk);
        reset = 1'b0;
        pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        div_valid = 1'b0; div_waddr = '0; div_wdata = '0;
        #1;
        check_quiet("reset");

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h7);
        check_write("s1.acc", 1'b0, 5'd0, 32'd0, 1'b0);
        check("s1.ready", {63'd0, div_ready}, 64'd1);
        idle();
        check_write("s1.wr", 1'b1, 5'd5, 32'h7, 1'b0);
        check("s1.pend", {63'd0, buf_empty}, 64'd0);
        idle();
        check_quiet("s1.done");

        starve_run("s2");

        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA00);
        check("s3.rdy1", {63'd0, div_ready}, 64'd1);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hB00);
        check("s3.rdy2", {63'd0, div_ready}, 64'd1);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC00);
        check("s3.full", {63'd0, div_ready}, 64'd0);
        check_write("s3.pipe", 1'b1, 5'd3, 32'h33, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC00);
        check("s3.full_pop", {63'd0, div_ready}, 64'd0);
        check_write("s3.h10", 1'b1, 5'd10, 32'hA00, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC00);
        check("s3.rdy3", {63'd0, div_ready}, 64'd1);
        check_write("s3.h11", 1'b1, 5'd11, 32'hB00, 1'b0);
        idle();
        check_write("s3.h12", 1'b1, 5'd12, 32'hC00, 1'b0);
        idle();
        check_quiet("s3.done");

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
        drive(1'b1, 5'd4, 32'hAAAA5555, 1'b0, 5'd0, 32'd0);
        check_write("s4.pipe", 1'b1, 5'd4, 32'hAAAA5555, 1'b0);
        idle();
        check_write("s4.silent", 1'b0, 5'd0, 32'd0, 1'b0);
        check("s4.pend", {63'd0, buf_empty}, 64'd0);
        idle();
        check_quiet("s4.done");

        drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h55);
        check_write("s5.acc", 1'b0, 5'd0, 32'd0, 1'b0);
        drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        check_write("s5.pop", 1'b0, 5'd0, 32'd0, 1'b0);
        check("s5.pend", {63'd0, buf_empty}, 64'd0);
        idle();
        check_quiet("s5.done");

        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
        for (int k = 0; k < 3; k++) drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        check("s6.pend", {63'd0, buf_empty}, 64'd0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        #0;
        check_quiet("s6.rst");
        starve_run("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
